// File: rtl/adam_periph_uart_pkg.sv
// Shared definitions for the ADAM UART peripheral: FSM state codes,
// parity encodings and a parity helper used by both tx and rx.
package adam_periph_uart_pkg;

  localparam logic [2:0] UART_IDLE   = 3'd0;
  localparam logic [2:0] UART_START  = 3'd1;
  localparam logic [2:0] UART_DATA   = 3'd2;
  localparam logic [2:0] UART_PARITY = 3'd3;
  localparam logic [2:0] UART_STOP   = 3'd4;
  localparam logic [2:0] UART_PAUSED = 3'd5;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Parity over the low `len` bits; odd parity inverts the even result.
  function automatic logic data_parity(input logic [15:0] word,
                                       input logic [3:0]  len,
                                       input logic        sel);
    logic acc;
    acc = (sel == PARITY_ODD);
    for (int i = 0; i < 16; i++) begin
      if (i < int'(len)) acc = acc ^ word[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/adam_periph_uart_baud.sv
// Per-bit tick generator: counts clocks while enabled and pulses `tick`
// on the last clock of each bit time. A zero cycle count acts as one.
module adam_periph_uart_baud #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] cycles,
  output logic                  tick
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] limit;

  assign limit = (cycles == '0) ? ONE : cycles;
  assign tick  = enable && (count == limit - ONE);

  // Restarting on every tick keeps each bit exactly `limit` clocks long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/adam_periph_uart_tx.sv
// UART transmitter: accepts words on a valid/ready stream and serialises
// them as start, LSB-first data, optional parity and 1..4 stop bits.
module adam_periph_uart_tx
  import adam_periph_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  parity_select,
  input  logic                  parity_control,
  input  logic [3:0]            data_length,
  input  logic [1:0]            stop_bits,
  input  logic [DATA_WIDTH-1:0] baud_rate,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx
);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] baud_q;
  logic [3:0]            len_q;
  logic [3:0]            bit_cnt;
  logic [1:0]            stop_q;
  logic [1:0]            stop_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  bit_tick;
  logic                  busy;
  logic [2:0]            post_data_state;
  logic                  post_data_tx;

  // Held low through reset so nothing is accepted before the FSM is live.
  assign data_ready = (state == UART_IDLE) && !pause_req && !rst;
  assign busy = (state == UART_START) || (state == UART_DATA) ||
                (state == UART_PARITY) || (state == UART_STOP);

  always_comb begin
    post_data_state = par_en_q ? UART_PARITY : UART_STOP;
    post_data_tx    = par_en_q ? par_bit_q : 1'b1;
  end

  adam_periph_uart_baud #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .enable(busy),
    .cycles(baud_q),
    .tick  (bit_tick)
  );

  // Frame config is captured at accept so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UART_IDLE;
      tx        <= 1'b1;
      pause_ack <= 1'b0;
      shift     <= '0;
      baud_q    <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      stop_q    <= '0;
      stop_cnt  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        UART_IDLE: begin
          tx <= 1'b1;
          if (pause_req) begin
            state     <= UART_PAUSED;
            pause_ack <= 1'b1;
          end else if (data_valid) begin
            state     <= UART_START;
            tx        <= 1'b0;
            shift     <= data;
            baud_q    <= baud_rate;
            len_q     <= data_length;
            stop_q    <= stop_bits;
            par_en_q  <= parity_control;
            par_bit_q <= data_parity(data[15:0], data_length, parity_select);
            bit_cnt   <= '0;
            stop_cnt  <= '0;
          end
        end
        UART_START: begin
          if (bit_tick) begin
            if (len_q != 4'd0) begin
              state   <= UART_DATA;
              tx      <= shift[0];
              bit_cnt <= '0;
            end else begin
              state    <= post_data_state;
              tx       <= post_data_tx;
              stop_cnt <= '0;
            end
          end
        end
        UART_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == len_q - 4'd1) begin
              state    <= post_data_state;
              tx       <= post_data_tx;
              stop_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        UART_PARITY: begin
          if (bit_tick) begin
            state    <= UART_STOP;
            tx       <= 1'b1;
            stop_cnt <= '0;
          end
        end
        UART_STOP: begin
          if (bit_tick) begin
            if (stop_cnt == stop_q) begin
              state <= UART_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 2'd1;
            end
          end
        end
        UART_PAUSED: begin
          tx <= 1'b1;
          if (!pause_req) begin
            state     <= UART_IDLE;
            pause_ack <= 1'b0;
          end
        end
        default: begin
          state     <= UART_IDLE;
          tx        <= 1'b1;
          pause_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
